ram_cb_multilane: RTL and testbench

Parametrised circular sample buffer for the FIR datapath. It is the generalised successor of the fixed 16k x 18 / 4-lane buffer, with configurable sample width, depth and lanes per read. New behaviour over that buffer:
- a request/valid read handshake;
- a fill counter;
- zero-masking of never-written locations, so memory initialisation is not needed;
- a lane-order reverse mode for symmetric-tap filters.

---
 rtl/ram_cb_multilane_if.sv | 39 +++
 rtl/ram_cb_multilane.sv | 153 +++++++++++++++
 tb/tb_ram_cb_multilane.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ram_cb_multilane_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_cb_multilane_if
// Purpose  : Bus bundle for the multilane circular sample buffer. It groups
//            the write port, the read request/response handshake and the
//            fill level.
// Ports    : din/wen                  - write sample and enable
//            rd_req/addrin/rd_rev     - read request, group address, lane order
//            dout/dout_valid          - LANES*DW read data and its strobe
//            fill                     - number of valid samples (saturating)
// Modports : master drives requests/writes; slave is the buffer itself.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_cb_multilane_if #(
  parameter int DW         = 18,
  parameter int LANES      = 4,
  parameter int DEPTH_LOG2 = 14,
  parameter int RAW        = DEPTH_LOG2 - $clog2(LANES)
);
  logic [DW-1:0]       din;
  logic                wen;
  logic                rd_req;
  logic [RAW-1:0]      addrin;
  logic                rd_rev;
  logic [LANES*DW-1:0] dout;
  logic                dout_valid;
  logic [DEPTH_LOG2:0] fill;

  modport master (
    output din, wen, rd_req, addrin, rd_rev,
    input  dout, dout_valid, fill
  );

  modport slave (
    input  din, wen, rd_req, addrin, rd_rev,
    output dout, dout_valid, fill
  );
endinterface
`default_nettype wire

// File: rtl/ram_cb_multilane.sv
`default_nettype none
// ============================================================================
// Module   : ram_cb_multilane
// Purpose  : Circular sample buffer of 2^DEPTH_LOG2 samples of DW bits that
//            returns LANES consecutive-age samples per read, with a
//            request/valid handshake, a saturating fill counter, zero masking
//            of never-written ages and a lane-order reverse mode.
// Ports    : clock   - rising-edge clock
//            reset_n - asynchronous active-low reset
//            bus     - ram_cb_multilane_if.slave (din, wen, rd_req, addrin,
//                      rd_rev, dout, dout_valid, fill)
// Timing   : request sampled at edge N, RAM data register at N+1, rotate /
//            mask / output register at N+2; dout_valid strobes after N+2.
// Revision : 1.0 - initial release
// ============================================================================
module ram_cb_multilane #(
  parameter int DW         = 18,
  parameter int LANES      = 4,
  parameter int DEPTH_LOG2 = 14
) (
  input wire logic          clock,
  input wire logic          reset_n,
  ram_cb_multilane_if.slave bus
);
  localparam int c_LW    = $clog2(LANES);
  localparam int c_LWS   = (c_LW == 0) ? 1 : c_LW;
  localparam int RAW     = DEPTH_LOG2 - c_LW;
  localparam int c_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] c_LMASK = DEPTH_LOG2'(LANES - 1);

  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2:0]   r_fill;

  // ---------------------------------------------------------------- write side
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_fill <= '0;
    end else if (bus.wen) begin
      r_wptr <= r_wptr + 1'b1;
      if (r_fill != (DEPTH_LOG2+1)'(c_DEPTH)) r_fill <= r_fill + 1'b1;
    end
  end

  assign bus.fill = r_fill;

  // ---------------------------------------------------------- read addressing
  // Age of lane-slot k is group+k. The group covers absolute addresses
  // base .. base+LANES-1 where base = wptr - group - LANES (age LANES-1 at
  // base, age 0 at the top). Since the group is LANES-aligned in age but not
  // in address, every bank is hit exactly once at its own entry.
  logic [DEPTH_LOG2-1:0] w_group;
  logic [DEPTH_LOG2-1:0] w_base;
  logic [LANES-1:0]      w_mask;

  assign w_group = DEPTH_LOG2'(bus.addrin) << c_LW;
  assign w_base  = r_wptr - w_group - DEPTH_LOG2'(LANES);

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_mask
      // Mask is taken from the fill seen in the request cycle.
      assign w_mask[k] = ({1'b0, w_group + DEPTH_LOG2'(k)} >= r_fill);
    end
  endgenerate

  // --------------------------------------------------------------- RAM banks
  logic [DEPTH_LOG2-1:0] w_wbank;
  logic [RAW-1:0]        w_wentry;
  logic [LANES*DW-1:0]   w_bank_q;

  assign w_wbank  = r_wptr & c_LMASK;
  assign w_wentry = RAW'(r_wptr >> c_LW);

  generate
    for (genvar b = 0; b < LANES; b++) begin : g_bank
      logic [DW-1:0]         r_mem [2**RAW];
      logic [DW-1:0]         r_q1;
      logic [DW-1:0]         r_q2;
      logic [DEPTH_LOG2-1:0] w_off;
      logic [DEPTH_LOG2-1:0] w_p;
      logic [RAW-1:0]        w_rentry;

      assign w_off    = (DEPTH_LOG2'(b) - w_base) & c_LMASK;
      assign w_p      = w_base + w_off;
      assign w_rentry = RAW'(w_p >> c_LW);

      // Read and write share an edge; the read sees the old contents, so a
      // write issued in the request cycle never leaks into that read.
      always_ff @(posedge clock) begin
        if (bus.wen && (w_wbank == DEPTH_LOG2'(b))) r_mem[w_wentry] <= bus.din;
        if (bus.rd_req) r_q1 <= r_mem[w_rentry];
        r_q2 <= r_q1;
      end

      assign w_bank_q[b*DW +: DW] = r_q2;
    end
  endgenerate

  // -------------------------------------------------------- request pipeline
  logic             r1_vld, r2_vld;
  logic             r1_rev, r2_rev;
  logic [c_LWS-1:0] r1_lo,  r2_lo;
  logic [LANES-1:0] r1_mask, r2_mask;

  always_ff @(posedge clock) begin
    if (bus.rd_req) begin
      r1_rev  <= bus.rd_rev;
      r1_lo   <= w_base[c_LWS-1:0];
      r1_mask <= w_mask;
    end
    r2_rev  <= r1_rev;
    r2_lo   <= r1_lo;
    r2_mask <= r1_mask;
  end

  // --------------------------------------------------- rotate, mask, output
  // Age slot k lives at address base+LANES-1-k, i.e. bank (lo+LANES-1-k).
  logic [LANES*DW-1:0] w_lanes;

  always_comb begin
    int k;
    int idx;
    w_lanes = '0;
    k       = 0;
    idx     = 0;
    for (int j = 0; j < LANES; j++) begin
      k   = r2_rev ? j : (LANES - 1 - j);
      idx = (int'(32'(r2_lo)) + LANES - 1 - k) % LANES;
      if (!r2_mask[k]) w_lanes[j*DW +: DW] = w_bank_q[idx*DW +: DW];
    end
  end

  logic [LANES*DW-1:0] r_dout;
  logic                r_dout_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r1_vld       <= 1'b0;
      r2_vld       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
    end else begin
      r1_vld       <= bus.rd_req;
      r2_vld       <= r1_vld;
      r_dout_valid <= r2_vld;
      if (r2_vld) r_dout <= w_lanes;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
endmodule
`default_nettype wire

// File: tb/tb_ram_cb_multilane.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_cb_multilane
// Purpose  : Scoreboard bench for ram_cb_multilane with default parameters
//            (DW=18, LANES=4, DEPTH_LOG2=14). Requests push the expected
//            lane word and strobe cycle; a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_cb_multilane;
  localparam int DW         = 18;
  localparam int LANES      = 4;
  localparam int DEPTH_LOG2 = 14;
  localparam int RAW        = DEPTH_LOG2 - 2;

  typedef struct {
    logic [LANES*DW-1:0] data;
    int                  cyc;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  ram_cb_multilane_if #(.DW(DW), .LANES(LANES), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  ram_cb_multilane #(.DW(DW), .LANES(LANES), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [LANES*DW-1:0] pack4(input int l3, input int l2,
                                                input int l1, input int l0);
    pack4 = {DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  task automatic chk(input string name, input logic [LANES*DW-1:0] act,
                     input logic [LANES*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding request.
  always @(negedge clock) begin
    if (reset_n && bus.dout_valid) begin
      if (exp_q.size() == 0) begin
        chk_i("unexpected_strobe", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dout", bus.dout, mon_e.data);
        chk_i("strobe_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    exp_q.delete();
    idle(2);
    reset_n = 1'b1;
  endtask

  task automatic wr_burst(input int first, input int n);
    bus.wen = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.din = DW'(first + i);
      @(negedge clock);
    end
    bus.wen = 1'b0;
  endtask

  // One-cycle read request, optionally with a concurrent write.
  task automatic req(input int addr, input logic rev, input logic [LANES*DW-1:0] exp,
                     input logic wr = 1'b0, input int wv = 0);
    bus.rd_req = 1'b1;
    bus.addrin = RAW'(addr);
    bus.rd_rev = rev;
    bus.wen    = wr;
    bus.din    = DW'(wv);
    exp_q.push_back('{exp, cyc + 3});
    @(negedge clock);
    bus.rd_req = 1'b0;
    bus.wen    = 1'b0;
  endtask

  initial begin
    bus.din    = '0;
    bus.wen    = 1'b0;
    bus.rd_req = 1'b0;
    bus.addrin = '0;
    bus.rd_rev = 1'b0;
    idle(3);

    // Reset state
    chk_i("reset_valid", int'(bus.dout_valid), 0);
    chk("reset_dout", bus.dout, '0);
    chk_i("reset_fill", int'(bus.fill), 0);
    reset_n = 1'b1;
    idle(1);

    // Empty buffer: everything masked, strobe two edges after the request
    req(0, 1'b0, '0);
    chk_i("t1_fill", int'(bus.fill), 0);
    idle(4);

    // Full lane groups, both orders
    wr_burst(1, 8);
    chk_i("t2_fill", int'(bus.fill), 8);
    req(0, 1'b0, pack4(8, 7, 6, 5));
    req(1, 1'b0, pack4(4, 3, 2, 1));
    req(0, 1'b1, pack4(5, 6, 7, 8));
    idle(4);

    // Partial fill: ages 6 and 7 masked
    apply_reset();
    wr_burst(1, 6);
    chk_i("t3_fill", int'(bus.fill), 6);
    req(1, 1'b0, pack4(2, 1, 0, 0));
    req(0, 1'b1, pack4(3, 4, 5, 6));
    idle(4);

    // Wrap: oldest group is samples 4..7 (age 16383 = sample 4 in lane 0)
    apply_reset();
    wr_burst(1, 16387);
    chk_i("t4_fill", int'(bus.fill), 16384);
    req(4095, 1'b0, pack4(7, 6, 5, 4));
    idle(4);
    // Same read with a write landing on the sample of age 16383
    req(4095, 1'b0, pack4(7, 6, 5, 4), 1'b1, 16388);
    idle(4);
    chk_i("t4_fill_sat", int'(bus.fill), 16384);

    // Pipelined requests, each relative to its own write pointer
    apply_reset();
    wr_burst(1, 16);
    req(0, 1'b0, pack4(16, 15, 14, 13), 1'b1, 17);
    req(1, 1'b0, pack4(13, 12, 11, 10), 1'b1, 18);
    req(2, 1'b0, pack4(10, 9, 8, 7), 1'b1, 19);
    idle(5);
    chk_i("t5_fill", int'(bus.fill), 19);

    // Reset between request and strobe: no strobe, immediate clear
    req(0, 1'b0, pack4(19, 18, 17, 16));
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_dout_async", bus.dout, '0);
    chk_i("t6_fill_async", int'(bus.fill), 0);
    chk_i("t6_valid_async", int'(bus.dout_valid), 0);
    idle(3);
    reset_n = 1'b1;
    idle(4);
    req(0, 1'b0, '0);
    req(5, 1'b1, '0);
    idle(4);
    chk_i("t6_fill_after", int'(bus.fill), 0);
    wr_burst(42, 1);
    req(0, 1'b0, pack4(42, 0, 0, 0));
    idle(6);

    chk_i("pending_strobes", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
